grid_row_scheduler: RTL
=======================

GRID_ROW_SCHEDULER -- requirements
Module: grid_row_scheduler

Interface
REQ-001 Parameter ROWS, default 4, number of grid rows; legal range is 2 or more.
REQ-002 Parameter COLS, default 4, bits per row; legal range is 1 or more.
REQ-003 Parameter NREQ, default 2, number of row-write requesters; legal range is 2 or more.
REQ-004 Derived constant RW = $clog2(ROWS), the row-index width.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_req  input  NREQ  per-requester row-write request.
REQ-008 wr_row  input  NREQ x RW  per-requester target row index.
REQ-009 wr_data  input  NREQ x COLS  per-requester row data.
REQ-010 wr_gnt  output  NREQ  one-hot (or zero) grant, combinational from wr_req and internal state.
REQ-011 scan_start  input  1  request a full-grid row scan.
REQ-012 scan_busy  output  1  high while in SCAN or DONE.
REQ-013 scan_valid, scan_ready  output/input  1 each  scan-out handshake.
REQ-014 scan_row_idx  output  RW  index of the row currently presented.
REQ-015 scan_data  output  COLS  contents of that row.
REQ-016 scan_done  output  1  one-cycle completion pulse.
REQ-017 grid_out  output  ROWS*COLS  flattened grid; bit r*COLS+c holds row r, column c.

Function
REQ-018 The block SHALL store a ROWS x COLS bit grid in flops.
REQ-019 The FSM SHALL have three states:
- IDLE: SCAN on scan_start.
- SCAN: DONE on a handshake (valid and ready) at row ROWS-1.
- DONE: always IDLE after one cycle.
REQ-020 In IDLE, wr_gnt SHALL go to one requester with wr_req high, selected round-robin starting from rr_ptr.
REQ-021 rr_ptr SHALL reset to 0 and, after a grant to requester k, become (k+1) mod NREQ.
REQ-022 A granted write SHALL update grid[wr_row] with wr_data at the next posedge, giving 1-cycle write latency.
REQ-023 A grant with wr_row >= ROWS SHALL leave the grid unchanged; the grant and rr_ptr update still occur.
REQ-024 In SCAN and DONE, wr_gnt SHALL be all-zero, the grid SHALL be frozen and rr_ptr SHALL hold.
REQ-025 When scan_start and wr_req are high in the same IDLE cycle, the write SHALL be granted and land, and the scan SHALL include it.
REQ-026 scan_start asserted at cycle t in IDLE SHALL give scan_valid=1 and scan_row_idx=0 at cycle t+1.
REQ-027 In SCAN, scan_valid SHALL be 1 and scan_data SHALL equal grid[scan_row_idx].
REQ-028 scan_row_idx SHALL increment only on a handshake and SHALL hold while scan_ready=0.
REQ-029 The handshake on row ROWS-1 SHALL move the FSM to DONE, with scan_done=1 and scan_valid=0 for exactly one cycle.
REQ-030 scan_start SHALL be ignored in SCAN and DONE.
REQ-031 grid_out SHALL reflect the grid at all times.

Reset
REQ-032 Asserting rst, at any time including mid-scan, SHALL immediately apply:
- grid = 0, rr_ptr = 0, state = IDLE;
- scan_row_idx = 0;
- scan_valid = 0, scan_busy = 0, scan_done = 0;
- grid_out = 0.
REQ-033 wr_gnt SHALL be 0 while rst is high.
REQ-034 A scan interrupted by reset SHALL NOT produce scan_done.

Structure
REQ-035 Package grid_sched_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and the row-index width helper function.
REQ-036 Round-robin selection SHALL be a sub-module named rr_arbiter, parameterised by NREQ, with inputs req, ptr and enable and output gnt.

Verification
REQ-037 Single write: ROWS=4, COLS=4, NREQ=2, wr_req=01, wr_row[0]=2, wr_data[0]=1010.
- Required: wr_gnt=01 in the same cycle.
- Required next cycle: grid_out[11:8]=1010.
REQ-038 Round-robin fairness: both requesters hold wr_req=11 for 4 cycles.
- Required: wr_gnt sequence 01, 10, 01, 10.
REQ-039 Scan with backpressure: grid rows = 1,2,3,4; pulse scan_start; scan_ready low for 2 cycles at row 1.
- Required: scan_data 0001, 0010 (held 3 cycles), 0011, 0100.
- Required: scan_done pulse one cycle after the row-3 handshake.
REQ-040 Write blocked during scan: wr_req=01 held throughout the scan.
- Required: wr_gnt=00 until state returns to IDLE.
- Required: the grant then issues and the grid updates the cycle after.
REQ-041 Simultaneous start and write, then out-of-range row:
- scan_start with a write of 1111 to row 0 in the same IDLE cycle: the first scan_data is 1111.
- A write with wr_row=5 under ROWS=4, RW=3 variant: granted, grid unchanged.
REQ-042 Reset mid-scan: assert rst at row 2.
- Required same cycle: scan_valid=0, grid_out=0, wr_gnt=0.
- Required: no scan_done pulse; IDLE after release.

Source files
------------

// File: rtl/grid_sched_pkg.sv
// Shared types and helpers for the grid row scheduler: scan FSM states and
// the row-index width rule.
package grid_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row-index width; never narrower than one bit.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping around; no grant when enable is low.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (enable && !found && req[j] && (j == (int'(ptr) + i) % NREQ)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/grid_row_scheduler.sv
// Row-granular bit grid with round-robin row writers and a handshaked
// full-grid scan-out; writes are blocked while a scan is in progress.
module grid_row_scheduler
  import grid_sched_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int NREQ = 2,
  parameter int RW   = row_w(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      wr_req,
  input  logic [NREQ*RW-1:0]   wr_row,
  input  logic [NREQ*COLS-1:0] wr_data,
  output logic [NREQ-1:0]      wr_gnt,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 scan_valid,
  input  logic                 scan_ready,
  output logic [RW-1:0]        scan_row_idx,
  output logic [COLS-1:0]      scan_data,
  output logic                 scan_done,
  output logic [ROWS*COLS-1:0] grid_out
);

  localparam int PW = $clog2(NREQ);

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [COLS-1:0] grid_q [ROWS];
  logic [RW-1:0]   row_idx_q;
  logic            valid_q, done_q;

  logic            arb_en, gnt_any, row_ok;
  logic [RW-1:0]   sel_row;
  logic [COLS-1:0] sel_data;

  // Grants are masked combinationally by rst so nothing is granted during reset.
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (wr_req),
    .ptr    (rr_ptr_q),
    .enable (arb_en),
    .gnt    (wr_gnt)
  );

  always_comb begin
    gnt_any  = 1'b0;
    sel_row  = '0;
    sel_data = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (wr_gnt[k]) begin
        gnt_any  = 1'b1;
        sel_row  = wr_row[k*RW +: RW];
        sel_data = wr_data[k*COLS +: COLS];
        rr_ptr_d = PW'((k + 1) % NREQ);
      end
    end
    row_ok = int'(sel_row) < ROWS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      row_idx_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            rr_ptr_q <= rr_ptr_d;
            if (row_ok) grid_q[sel_row] <= sel_data;
          end
          if (scan_start) begin
            state_q   <= SCAN;
            valid_q   <= 1'b1;
            row_idx_q <= '0;
          end
        end
        SCAN: begin
          if (scan_ready) begin
            if (row_idx_q == RW'(ROWS - 1)) begin
              state_q   <= DONE;
              valid_q   <= 1'b0;
              done_q    <= 1'b1;
              row_idx_q <= '0;
            end else begin
              row_idx_q <= row_idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_busy    = (state_q != IDLE);
  assign scan_valid   = valid_q;
  assign scan_done    = done_q;
  assign scan_row_idx = row_idx_q;
  assign scan_data    = grid_q[row_idx_q];

  for (genvar r = 0; r < ROWS; r++) begin : g_flat
    assign grid_out[r*COLS +: COLS] = grid_q[r];
  end

endmodule
